// File: rtl/counter_seq_ctrl.sv
// Sequenced one-shot / periodic timer built around a prescaled up-counter.
// Latency: done rises (term_q+1)*(prescale_q+1) cycles after the start-accepting edge (plus cycles spent in HOLD).
// Backpressure: none; hold freezes a running sequence, stop aborts it, and start is ignored while busy.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start/stop/hold control requests, sampled every cycle (hold is a level)
//   term_val        terminal count, captured on an accepted start
//   prescale        counter advances every prescale+1 cycles, captured on an accepted start
//   count           registered counter value
//   busy / held     state is RUN or HOLD / state is HOLD
//   done            registered one-cycle completion pulse
//   auto_reload     present only with COUNTER_SEQ_CTRL_AUTORELOAD_EN: periodic mode when high at completion
//
// Optional feature macro: COUNTER_SEQ_CTRL_AUTORELOAD_EN
module counter_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
`ifdef COUNTER_SEQ_CTRL_AUTORELOAD_EN
  input  logic             auto_reload,
`endif
  input  logic [WIDTH-1:0] term_val,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             held,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       state_q,    state_d;
  logic [WIDTH-1:0] count_q,    count_d;
  logic [PRE_W-1:0] pre_cnt_q,  pre_cnt_d;
  logic [WIDTH-1:0] term_q,     term_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic             done_q,     done_d;
  logic             tick;
  logic             reload;

`ifdef COUNTER_SEQ_CTRL_AUTORELOAD_EN
  assign reload = auto_reload;
`else
  assign reload = 1'b0;
`endif

  assign tick = (state_q == S_RUN) && (pre_cnt_q == prescale_q);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pre_cnt_d  = pre_cnt_q;
    term_d     = term_q;
    prescale_d = prescale_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // stop beats start; nothing is captured when both are high
        if (start && !stop) begin
          term_d     = term_val;
          prescale_d = prescale;
          count_d    = '0;
          pre_cnt_d  = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (hold) begin
          // freeze on this edge so the resumed sequence sees the same pre_cnt
          state_d = S_HOLD;
        end else if (tick) begin
          pre_cnt_d = '0;
          if (count_q != term_q) begin
            count_d = count_q + 1'b1;
          end else begin
            // completion is checked before incrementing, so term_q at full scale never wraps
            done_d = 1'b1;
            if (reload) begin
              count_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else begin
          pre_cnt_d = pre_cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (!hold) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      pre_cnt_q  <= '0;
      term_q     <= '0;
      prescale_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pre_cnt_q  <= pre_cnt_d;
      term_q     <= term_d;
      prescale_q <= prescale_d;
      done_q     <= done_d;
    end
  end

  assign count = count_q;
  assign done  = done_q;
  assign busy  = (state_q != S_IDLE);
  assign held  = (state_q == S_HOLD);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl.
// The model tracks sequence progress as a count of advancing edges; count and done follow from arithmetic on it.
module tb_counter_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int PRE_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             hold = 1'b0;
  logic             auto_reload = 1'b0;
  logic [WIDTH-1:0] term_val = '0;
  logic [PRE_W-1:0] prescale = '0;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             held;
  logic             done;

  int total = 0;
  int passed = 0;
  int n = 0;

  counter_seq_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .hold        (hold),
`ifdef COUNTER_SEQ_CTRL_AUTORELOAD_EN
    .auto_reload (auto_reload),
`endif
    .term_val    (term_val),
    .prescale    (prescale),
    .count       (count),
    .busy        (busy),
    .held        (held),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // m_st: 0 idle, 1 running, 2 held. m_p counts advancing edges since the start.
  bit m_valid = 1'b0;
  int m_st = 0;
  int m_p = 0;
  int m_term = 0;
  int m_pre = 0;
  int m_cnt = 0;
  int m_done = 0;

  always @(posedge clk) begin
    int period;
    bit ar;
`ifdef COUNTER_SEQ_CTRL_AUTORELOAD_EN
    ar = auto_reload;
`else
    ar = 1'b0;
`endif
    m_done = 0;
    if (reset) begin
      m_st = 0; m_p = 0; m_term = 0; m_pre = 0; m_cnt = 0;
      m_valid = 1'b1;
    end else begin
      case (m_st)
        0: if (start && !stop) begin
             m_term = int'(term_val); m_pre = int'(prescale);
             m_p = 0; m_cnt = 0; m_st = 1;
           end
        1: if (stop) m_st = 0;
           else if (hold) m_st = 2;
           else begin
             m_p++;
             period = (m_term + 1) * (m_pre + 1);
             if (m_p == period) begin
               m_done = 1;
               if (ar) begin m_p = 0; m_cnt = 0; end
               else begin m_cnt = m_term; m_st = 0; end
             end else begin
               m_cnt = m_p / (m_pre + 1);
             end
           end
        default: if (stop) m_st = 0;
                 else if (!hold) m_st = 1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("count", int'(count), m_cnt);
      chk("busy",  int'(busy),  (m_st != 0) ? 1 : 0);
      chk("held",  int'(held),  (m_st == 2) ? 1 : 0);
      chk("done",  int'(done),  m_done);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic start_seq(input int t, input int p);
    term_val = WIDTH'(t);
    prescale = PRE_W'(p);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
  endtask

  // advance until done is seen, bounded; reports the edge count since the start edge
  task automatic wait_done(input string name, input int exp);
    while (!done && n < 400) step();
    chk(name, done ? n : -1, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_count", int'(count), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_held",  int'(held), 0);

    // term 3, prescale 0: done 4 cycles after start, count left at 3
    start_seq(3, 0);
    chk("t3_count0", int'(count), 0);
    step();
    chk("t3_count1", int'(count), 1);
    wait_done("t3_latency", 4);
    chk("t3_count_end", int'(count), 3);
    chk("t3_busy_end", int'(busy), 0);
    step();
    chk("t3_done_clr", int'(done), 0);
    chk("t3_count_hold", int'(count), 3);

    // term 2, prescale 2; mid-run input changes must not matter
    start_seq(2, 2);
    term_val = 4'd15;
    prescale = 4'd15;
    step(); step();
    chk("p2_count_at2", int'(count), 0);
    step();
    chk("p2_count_at3", int'(count), 1);
    wait_done("p2_latency", 9);

    // term 5 with hold sampled on 3 edges at count 2; resume edge also frozen -> 4 lost cycles
    step();
    start_seq(5, 0);
    step(); step();
    chk("h_count_pre", int'(count), 2);
    hold = 1'b1;
    step(); step(); step();
    chk("h_held", int'(held), 1);
    chk("h_count_frozen", int'(count), 2);
    hold = 1'b0;
    wait_done("h_latency", 10);

    // term 7, stop at count 4
    step();
    start_seq(7, 0);
    repeat (4) step();
    chk("s_count_pre", int'(count), 4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("s_count_after", int'(count), 4);
    chk("s_busy_after", int'(busy), 0);
    repeat (10) step();
    // start together with stop must not launch
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", int'(busy), 0);

    // reset while running at count 6
    start_seq(9, 0);
    repeat (6) step();
    chk("r_count_pre", int'(count), 6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("r_count", int'(count), 0);
    chk("r_busy", int'(busy), 0);

    // term 0: done one cycle after start
    start_seq(0, 0);
    wait_done("t0_latency", 1);

    // full-scale terminal value
    step();
    start_seq(15, 0);
    wait_done("t15_latency", 16);
    chk("t15_count", int'(count), 15);

    // restart accepted in the done cycle
    step();
    start_seq(1, 1);
    wait_done("rs_first", 4);
    start_seq(2, 0);
    chk("rs_done_drop", int'(done), 0);
    chk("rs_busy", int'(busy), 1);
    wait_done("rs_second", 3);

`ifdef COUNTER_SEQ_CTRL_AUTORELOAD_EN
    step();
    auto_reload = 1'b1;
    start_seq(1, 0);
    wait_done("ar_first", 2);
    chk("ar_busy", int'(busy), 1);
    step();
    wait_done("ar_second", 4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    auto_reload = 1'b0;
    chk("ar_stopped", int'(busy), 0);
`endif

    step(); step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
